// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned FQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// PC-stage, instruction-memory and decode handshakes of the fetch queue.
// The slave modport is the queue's view; master is the surrounding pipeline.
interface fetch_queue_if;

  logic [fetch_pkg::XLEN-1:0] if_pc;
  logic                       if_valid;
  logic                       if_ready;
  logic                       flush;
  logic                       imem_req_valid;
  logic [fetch_pkg::XLEN-1:0] imem_req_addr;
  logic                       imem_req_ready;
  logic                       imem_rsp_valid;
  logic [fetch_pkg::XLEN-1:0] imem_rsp_data;
  logic                       dec_valid;
  logic                       dec_ready;
  logic [fetch_pkg::XLEN-1:0] dec_pc;
  logic [fetch_pkg::XLEN-1:0] dec_instr;

  modport slave (
    input  if_pc, if_valid, flush, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, dec_ready,
    output if_ready, imem_req_valid, imem_req_addr, dec_valid, dec_pc,
           dec_instr
  );

  modport master (
    output if_pc, if_valid, flush, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, dec_ready,
    input  if_ready, imem_req_valid, imem_req_addr, dec_valid, dec_pc,
           dec_instr
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order fetches, buffers {pc, instr}
// pairs and hands them to decode. Flushed in-flight responses are tracked
// in a drop counter and discarded as they return.
// Optional macro FETCH_QUEUE_BYPASS_EN: forward a response straight to
// decode when it belongs to the head entry and nothing else is filled.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int unsigned    PW      = $clog2(DEPTH);
  localparam int unsigned    CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0]  P_ONE   = PW'(1);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);

  fq_entry_t       entries [DEPTH];
  logic [PW-1:0]   alloc_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0]   count, drop;
  logic [PW-1:0]   ptr_diff;
  logic [CW-1:0]   pend;
  logic            credit, req_valid, req_fire;
  logic            rsp_ok, rsp_drop, bypass, dec_valid, pop;
  fq_entry_t       head;

  // Entries allocated but not yet filled. alloc == fill is ambiguous only
  // when the queue is full: then the entry at fill tells empty from all-pending.
  always_comb begin
    ptr_diff = alloc_ptr - fill_ptr;
    pend     = '0;
    if (alloc_ptr != fill_ptr) begin
      pend = {1'b0, ptr_diff};
    end else if (count == DEPTH_C && !entries[fill_ptr].filled) begin
      pend = DEPTH_C;
    end
  end

  // Request issue, response classification and decode presentation.
  always_comb begin
    head      = entries[rd_ptr];
    credit    = (count + drop) < DEPTH_C;
    req_valid = bus.if_valid && credit && !bus.flush && !reset;
    req_fire  = req_valid && bus.imem_req_ready;
    rsp_drop  = bus.imem_rsp_valid && (drop != '0);
    rsp_ok    = bus.imem_rsp_valid && (drop == '0) && (pend != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass        = rsp_ok && (count != '0) && (count == pend);
    dec_valid     = !reset && !bus.flush && (count != '0) && (head.filled || bypass);
    bus.dec_instr = bypass ? bus.imem_rsp_data : head.instr;
`else
    bypass        = 1'b0;
    dec_valid     = !reset && !bus.flush && (count != '0) && head.filled;
    bus.dec_instr = head.instr;
`endif
    pop                = dec_valid && bus.dec_ready;
    bus.dec_valid      = dec_valid;
    bus.dec_pc         = head.pc;
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = bus.if_pc;
    bus.if_ready       = req_fire;
  end

  // Pointer, counter and entry storage updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (bus.flush) begin
      // Every still-pending entry becomes a response to drop; a response
      // landing this cycle is discarded directly, so it is not counted.
      fill_ptr <= alloc_ptr;
      rd_ptr   <= alloc_ptr;
      count    <= '0;
      drop     <= drop + pend - {{PW{1'b0}}, rsp_ok} - {{PW{1'b0}}, rsp_drop};
    end else begin
      if (req_fire) begin
        entries[alloc_ptr].pc     <= bus.if_pc;
        entries[alloc_ptr].filled <= 1'b0;
        alloc_ptr                 <= alloc_ptr + P_ONE;
      end
      if (rsp_drop) begin
        drop <= drop - C_ONE;
      end
      if (rsp_ok) begin
        entries[fill_ptr].instr  <= bus.imem_rsp_data;
        entries[fill_ptr].filled <= !(bypass && bus.dec_ready);
        fill_ptr                 <= fill_ptr + P_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + P_ONE;
      end
      count <= count + {{PW{1'b0}}, req_fire} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a constant streaming table, hand
// sequences for full / flush / reset / bypass corners, and a randomized run
// against a queue-based reference model with an in-order memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          have;
  } ment_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    bit          iv;
    logic [31:0] pc;
    bit          e_rdy;
    bit          e_dv;
    logic [31:0] e_pc;
  } vec_t;

  ment_t       q[$];
  mreq_t       mq[$];
  int          drop;
  int          cyc;
  int          last_due;
  int          lat_lo, lat_hi;
  int          n_checks, n_pass;

  bit          s_iv, s_rr, s_dr, s_fl, s_reset;
  logic [31:0] s_pc;

  logic        smp_req_valid, smp_if_ready, smp_dv;
  logic [31:0] smp_pc, smp_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step();
    bit          rv, credit, e_req, e_rdy, rsp_ok, byp, e_dv;
    logic [31:0] rdata;
    int          pend, firstp, lat, due;
    bus.if_valid       = s_iv;
    bus.if_pc          = s_pc;
    bus.imem_req_ready = s_rr;
    bus.dec_ready      = s_dr;
    bus.flush          = s_fl;
    reset              = s_reset;
    rv    = (mq.size() > 0) && (mq[0].due <= cyc);
    rdata = rv ? mem_word(mq[0].addr) : 32'h0;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rdata;
    #4;
    smp_req_valid = bus.imem_req_valid;
    smp_if_ready  = bus.if_ready;
    smp_dv        = bus.dec_valid;
    smp_pc        = bus.dec_pc;
    smp_instr     = bus.dec_instr;
    if (s_reset) begin
      chk("rst_req_valid", smp_req_valid, 0);
      chk("rst_dec_valid", smp_dv, 0);
      q.delete();
      mq.delete();
      drop     = 0;
      last_due = cyc;
    end else begin
      pend   = 0;
      firstp = -1;
      foreach (q[i]) if (!q[i].have) begin
        pend++;
        if (firstp < 0) firstp = i;
      end
      credit = (q.size() + drop) < DEPTH;
      e_req  = s_iv && credit && !s_fl;
      e_rdy  = e_req && s_rr;
      rsp_ok = rv && (drop == 0) && (pend > 0);
      byp    = BYP && rsp_ok && (q.size() > 0) && (pend == q.size());
      e_dv   = !s_fl && (q.size() > 0) && (q[0].have || byp);
      chk("req_valid", smp_req_valid, e_req);
      chk("if_ready", smp_if_ready, e_rdy);
      if (e_req) chk("req_addr", bus.imem_req_addr, s_pc);
      chk("dec_valid", smp_dv, e_dv);
      if (e_dv) begin
        chk("dec_pc", smp_pc, q[0].pc);
        chk("dec_instr", smp_instr, byp ? rdata : q[0].instr);
      end
      if (s_fl) begin
        drop = drop - ((rv && drop > 0) ? 1 : 0) + pend - (rsp_ok ? 1 : 0);
        q.delete();
      end else begin
        if (rv) begin
          if (drop > 0) drop--;
          else if (pend > 0) begin
            q[firstp].have  = 1'b1;
            q[firstp].instr = rdata;
          end
        end
        if (e_dv && s_dr) void'(q.pop_front());
        if (e_rdy) q.push_back('{pc: s_pc, instr: 32'h0, have: 1'b0});
      end
      if (e_rdy) begin
        lat = $urandom_range(lat_hi, lat_lo);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: s_pc, due: due});
      end
    end
    if (rv && !s_reset) void'(mq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    s_iv = 0; s_pc = '0; s_fl = 0; s_reset = 0;
  endtask

  task automatic do_reset();
    idle();
    s_reset = 1;
    step();
    s_reset = 0;
  endtask

  vec_t        tbl [7];
  int          k, idx, pops, t, first_seen;
  logic [31:0] pcs [6];
  logic [31:0] popped [$];
  logic [31:0] first_pc, first_instr, byp_instr1, byp_instr2;
  bit          byp_dv1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; drop = 0; last_due = 0;
    lat_lo = 1; lat_hi = 1;
    s_rr = 1; s_dr = 1;
    idle();
    do_reset();
    do_reset();

    // Reset state with idle inputs.
    step();
    chk("reset_req_valid", smp_req_valid, 0);
    chk("reset_if_ready", smp_if_ready, 0);
    chk("reset_dec_valid", smp_dv, 0);
    chk("reset_dec_pc", smp_pc, 0);
    chk("reset_dec_instr", smp_instr, 0);

    // Streaming table, memory latency 1, decode always ready.
    for (int r = 0; r < 7; r++) begin
      k = r - (BYP ? 1 : 2);
      tbl[r] = '{iv: (r < 4), pc: 32'(4 * r), e_rdy: (r < 4),
                 e_dv: (k >= 0 && k < 4), e_pc: 32'(4 * k)};
    end
    do_reset();
    s_rr = 1; s_dr = 1;
    for (int r = 0; r < 7; r++) begin
      s_iv = tbl[r].iv;
      s_pc = tbl[r].iv ? tbl[r].pc : 32'h0;
      step();
      chk("stream_if_ready", smp_if_ready, tbl[r].e_rdy);
      chk("stream_dec_valid", smp_dv, tbl[r].e_dv);
      if (tbl[r].e_dv) begin
        chk("stream_dec_pc", smp_pc, tbl[r].e_pc);
        chk("stream_dec_instr", smp_instr, mem_word(tbl[r].e_pc));
      end
    end

    // Full: six addresses offered with decode stalled.
    do_reset();
    s_dr = 0; s_rr = 1;
    for (int i = 0; i < 6; i++) pcs[i] = 32'h400 + 32'(4 * i);
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      s_iv = (idx < 6);
      s_pc = pcs[idx < 6 ? idx : 5];
      step();
      if (smp_if_ready) idx++;
    end
    chk("full_accepted", idx, 4);
    chk("full_if_ready_low", smp_if_ready, 0);
    s_dr = 1;
    pops = 0;
    popped.delete();
    for (int c = 0; c < 40 && pops < 6; c++) begin
      s_iv = (idx < 6);
      s_pc = pcs[idx < 6 ? idx : 5];
      step();
      if (smp_if_ready) idx++;
      if (smp_dv) begin
        popped.push_back(smp_pc);
        pops++;
      end
    end
    chk("full_total_accepted", idx, 6);
    chk("full_total_popped", pops, 6);
    for (int i = 0; i < 6; i++) begin
      chk("full_pop_order", (i < popped.size()) ? popped[i] : 32'hFFFF_FFFF, pcs[i]);
    end
    idle();

    // Flush with three requests in flight, latency 3.
    do_reset();
    lat_lo = 3; lat_hi = 3; s_rr = 1; s_dr = 1;
    for (int i = 0; i < 3; i++) begin
      s_iv = 1; s_pc = 32'h500 + 32'(4 * i);
      step();
    end
    s_fl = 1; s_iv = 1; s_pc = 32'h0000_0DE0;
    step();
    chk("flush_if_ready_blocked", smp_if_ready, 0);
    chk("flush_dec_valid_blocked", smp_dv, 0);
    s_fl = 0; s_iv = 1; s_pc = 32'h100;
    step();
    chk("flush_resume_if_ready", smp_if_ready, 1);
    idle();
    first_seen = 0; first_pc = '1; first_instr = '1;
    for (t = 0; t < 20 && !first_seen; t++) begin
      step();
      if (smp_dv) begin
        first_seen = 1; first_pc = smp_pc; first_instr = smp_instr;
      end
    end
    chk("flush_first_seen", first_seen, 1);
    chk("flush_first_pc", first_pc, 32'h100);
    chk("flush_first_instr", first_instr, mem_word(32'h100));

    // Flush coincident with a response and decode ready.
    do_reset();
    lat_lo = 2; lat_hi = 2; s_rr = 1; s_dr = 0;
    for (int i = 0; i < 3; i++) begin
      s_iv = 1; s_pc = 32'h200 + 32'(4 * i);
      step();
    end
    s_iv = 0; s_fl = 1; s_dr = 1;
    step();
    chk("coinc_no_pop", smp_dv, 0);
    s_fl = 0; s_iv = 1; s_pc = 32'h300;
    step();
    idle();
    first_seen = 0; first_pc = '1;
    for (t = 0; t < 20 && !first_seen; t++) begin
      step();
      if (smp_dv) begin
        first_seen = 1; first_pc = smp_pc;
      end
    end
    chk("coinc_first_seen", first_seen, 1);
    chk("coinc_first_pc", first_pc, 32'h300);

    // Reset mid-stream with two filled entries.
    do_reset();
    lat_lo = 1; lat_hi = 1; s_rr = 1; s_dr = 0;
    s_iv = 1; s_pc = 32'h600; step();
    s_pc = 32'h604; step();
    idle(); step(); step();
    chk("midrst_before_valid", smp_dv, 1);
    do_reset();
    step();
    chk("midrst_req_valid", smp_req_valid, 0);
    chk("midrst_if_ready", smp_if_ready, 0);
    chk("midrst_dec_valid", smp_dv, 0);
    chk("midrst_dec_pc", smp_pc, 0);
    chk("midrst_dec_instr", smp_instr, 0);

    // Response to an empty queue: same cycle with bypass, next cycle without.
    do_reset();
    lat_lo = 1; lat_hi = 1; s_rr = 1; s_dr = 1;
    s_iv = 1; s_pc = 32'h0; step();
    idle(); step();
    byp_dv1 = smp_dv; byp_instr1 = smp_instr;
    step();
    chk("byp_same_cycle_valid", byp_dv1, BYP);
    chk("byp_next_cycle_valid", smp_dv, !BYP);
    byp_instr2 = smp_instr;
    chk("byp_instr", BYP ? byp_instr1 : byp_instr2, 32'h0000_0013);

    // Randomized traffic against the reference model.
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int c = 0; c < 3000; c++) begin
      s_iv    = ($urandom_range(9, 0) < 7);
      s_pc    = $urandom & 32'hFFFF_FFFC;
      s_rr    = ($urandom_range(9, 0) < 8);
      s_dr    = ($urandom_range(9, 0) < 7);
      s_fl    = ($urandom_range(99, 0) < 3);
      s_reset = ($urandom_range(499, 0) == 0);
      step();
    end
    s_reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
